// File: rtl/alu_lockstep_ctrl.sv
// alu_lockstep_ctrl: retrying sequencer for the dual-lane lockstep ALU; optional lane-2 fault injection via LOCKSTEP_FAULT_INJECT_EN
module alu_lockstep_ctrl #(
  parameter int ALU_LAT   = 1,
  parameter int MAX_RETRY = 2,
  parameter int FCNT_W    = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_a,
  input  logic [3:0]        req_b,
  input  logic [1:0]        req_sel,
  output logic [3:0]        alu_a0,
  output logic [3:0]        alu_b0,
  output logic [1:0]        alu_sel1,
  output logic [3:0]        alu_a1,
  output logic [3:0]        alu_b1,
  output logic [1:0]        alu_sel2,
  input  logic [3:0]        alu_out1,
  input  logic              alu_cout1,
  input  logic [3:0]        alu_x,
  input  logic              alu_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_result,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic [2:0]        rsp_tries,
  output logic [FCNT_W-1:0] fault_cnt,
  output logic              irq_fault,
`ifdef LOCKSTEP_FAULT_INJECT_EN
  input  logic [3:0]        inj_mask,
  input  logic              inj_once,
`endif
  input  logic              irq_clr
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_RESP} state_t;
  localparam logic [2:0] LAT = 3'(ALU_LAT);
  localparam logic [2:0] MR  = 3'(MAX_RETRY);
  state_t state_q;
  logic [2:0] cnt_q, try_q, rsp_tries_q;
  logic [3:0] a_q, b_q, a1_q, rsp_result_q;
  logic [1:0] sel_q;
  logic req_ready_q, rsp_valid_q, rsp_carry_q, rsp_err_q, irq_q, mism;
  logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic [3:0] inj_m;
  logic inj_o;
`ifdef LOCKSTEP_FAULT_INJECT_EN
  assign inj_m = inj_mask;
  assign inj_o = inj_once;
`else
  assign inj_m = 4'h0;
  assign inj_o = 1'b0;
`endif
  assign mism        = (|alu_x) | alu_y;
  assign fault_cnt_d = fault_cnt_q + FCNT_W'(!(&fault_cnt_q));
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      try_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      a1_q         <= '0;
      sel_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tries_q  <= '0;
      fault_cnt_q  <= '0;
      irq_q        <= 1'b0;
    end else begin
      // a fault raised below in the same cycle overrides this clear
      if (irq_clr) irq_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          a_q         <= req_a;
          b_q         <= req_b;
          sel_q       <= req_sel;
          a1_q        <= req_a ^ inj_m;
          cnt_q       <= LAT;
          try_q       <= '0;
          req_ready_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= S_CHECK;
        end
        S_CHECK: if (mism && try_q != MR) begin
          try_q   <= try_q + 3'd1;
          cnt_q   <= LAT;
          a1_q    <= a_q ^ (inj_o ? 4'h0 : inj_m);
          state_q <= S_WAIT;
        end else begin
          rsp_result_q <= alu_out1;
          rsp_carry_q  <= alu_cout1;
          rsp_err_q    <= mism;
          rsp_tries_q  <= try_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
          if (mism) begin
            fault_cnt_q <= fault_cnt_d;
            irq_q       <= 1'b1;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign req_ready  = req_ready_q;
  assign alu_a0     = a_q;
  assign alu_b0     = b_q;
  assign alu_sel1   = sel_q;
  assign alu_a1     = a1_q;
  assign alu_b1     = b_q;
  assign alu_sel2   = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tries  = rsp_tries_q;
  assign fault_cnt  = fault_cnt_q;
  assign irq_fault  = irq_q;
endmodule

// File: tb/tb_alu_lockstep_ctrl.sv
// tb_alu_lockstep_ctrl: transaction-level model plus per-cycle compare for alu_lockstep_ctrl
module tb_alu_lockstep_ctrl;
  localparam int L = 1, MR = 2, FW = 8;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_carry, rsp_err;
  logic [3:0] req_a = 0, req_b = 0, a0, b0, a1, b1, out1, rsp_result, x = 0;
  logic [1:0] req_sel = 0, s1, s2;
  logic cout1, y = 0, irq_fault, irq_clr = 0;
  logic [2:0] rsp_tries;
  logic [FW-1:0] fault_cnt;
`ifdef LOCKSTEP_FAULT_INJECT_EN
  logic [3:0] inj_mask = 0;
  logic inj_once = 0;
`endif
  int n_chk = 0, n_fail = 0;
  logic [3:0] m_a = 0, m_b = 0, m_a1 = 0, e_res = 0;
  logic [1:0] m_sel = 0;
  bit m_idle = 1, m_resp = 0, m_irq = 0, e_carry = 0, e_err = 0;
  int m_fc = 0, e_tries = 0;

  function automatic logic [4:0] ref_alu(input logic [3:0] a, b, input logic [1:0] s);
    case (s)
      2'd0: return {1'b0, a} + {1'b0, b};
      2'd1: return {1'b0, a} - {1'b0, b};
      2'd2: return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  function automatic logic [3:0] mask_for(input int attempt);
`ifdef LOCKSTEP_FAULT_INJECT_EN
    return (inj_once && attempt > 0) ? 4'h0 : inj_mask;
`else
    return (attempt < 0) ? 4'hF : 4'h0;
`endif
  endfunction

  assign {cout1, out1} = ref_alu(a0, b0, s1);

  alu_lockstep_ctrl #(.ALU_LAT(L), .MAX_RETRY(MR), .FCNT_W(FW)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a0(a0), .alu_b0(b0), .alu_sel1(s1),
    .alu_a1(a1), .alu_b1(b1), .alu_sel2(s2),
    .alu_out1(out1), .alu_cout1(cout1), .alu_x(x), .alu_y(y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tries(rsp_tries),
    .fault_cnt(fault_cnt), .irq_fault(irq_fault),
`ifdef LOCKSTEP_FAULT_INJECT_EN
    .inj_mask(inj_mask), .inj_once(inj_once),
`endif
    .irq_clr(irq_clr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", req_ready, m_idle);
    chk("rsp_valid", rsp_valid, m_resp);
    chk("ready_valid_excl", rsp_valid & req_ready, 0);
    chk("lane_a0", a0, m_a);
    chk("lane_a1", a1, m_a1);
    chk("lane_b", {b1, b0}, {m_b, m_b});
    chk("lane_sel", {s2, s1}, {m_sel, m_sel});
    chk("fault_cnt", fault_cnt, m_fc);
    chk("irq_fault", irq_fault, m_irq);
    if (m_resp) begin
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_carry", rsp_carry, e_carry);
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_tries", rsp_tries, e_tries);
    end
  end

  // nbad > MR means every attempt mismatches (driven on y), otherwise the first nbad attempts mismatch on x
  task automatic set_bad(input bit bad, input bit use_y);
    x = (bad && !use_y) ? 4'h1 : 4'h0;
    y = bad && use_y;
  endtask

  // starts at an idle cycle; lat counts edges from accept edge (inclusive) to rsp_valid edge
  task automatic do_op(input logic [3:0] a, b, input logic [1:0] s, input int nbad, input int hold,
                       input bit keep, input bit clr, output int lat, output logic [3:0] res,
                       output logic [2:0] tries, output bit err);
    int att, e, first;
    logic [4:0] r;
    att = (nbad > MR) ? MR + 1 : nbad + 1;
    e = (L + 1) * att;
    first = 0;
    req_valid = 1; req_a = a; req_b = b; req_sel = s; irq_clr = clr;
    set_bad(nbad > 0, nbad > MR);
    @(posedge clk); #1;
    m_idle = 0; m_a = a; m_b = b; m_sel = s; m_a1 = a ^ mask_for(0);
    if (clr) m_irq = 0;
    if (keep) begin req_a = ~a; req_b = ~b; req_sel = ~s; end else req_valid = 0;
    r = ref_alu(a, b, s);
    e_res = r[3:0]; e_carry = r[4]; e_err = nbad > MR; e_tries = att - 1;
    for (int n = 1; n <= e; n++) begin
      @(posedge clk); #1;
      if (rsp_valid && first == 0) first = n;
      if (clr) m_irq = 0;
      if (n < e && n % (L + 1) == 0) begin
        set_bad(n / (L + 1) < nbad, nbad > MR);
        m_a1 = a ^ mask_for(n / (L + 1));
      end
      if (n == e) begin
        m_resp = 1;
        if (e_err) begin m_fc = (m_fc < 255) ? m_fc + 1 : 255; m_irq = 1; end
        irq_clr = 0;
        res = rsp_result; tries = rsp_tries; err = rsp_err;
      end
    end
    lat = first + 1;
    repeat (hold) @(posedge clk);
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0; m_resp = 0; m_idle = 1;
  endtask

  task automatic pulse_clr();
    @(negedge clk); irq_clr = 1;
    @(posedge clk); #1;
    irq_clr = 0; m_irq = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [3:0] res;
    logic [2:0] tries;
    bit err;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_fault_cnt", fault_cnt, 0);
    rst_n = 1;
    // clean operation: 3+5 = 8
    do_op(4'h3, 4'h5, 2'd0, 0, 0, 0, 0, lat, res, tries, err);
    chk("t1_latency", lat, 3);
    chk("t1_result", res, 4'h8);
    chk("t1_err_tries", {err, tries}, 4'b0000);
    chk("t1_irq", irq_fault, 0);
    // single mismatch then match: 9-2 = 7
    do_op(4'h9, 4'h2, 2'd1, 1, 0, 0, 0, lat, res, tries, err);
    chk("t2_latency", lat, 5);
    chk("t2_result", res, 4'h7);
    chk("t2_err_tries", {err, tries}, 4'b0001);
    chk("t2_fault_cnt", fault_cnt, 0);
    // persistent mismatch exhausts retries: 0xC & 0xA = 8
    do_op(4'hC, 4'hA, 2'd2, 9, 0, 0, 0, lat, res, tries, err);
    chk("t3_latency", lat, 7);
    chk("t3_result", res, 4'h8);
    chk("t3_err_tries", {err, tries}, 4'b1010);
    chk("t3_fault_cnt", fault_cnt, 1);
    chk("t3_irq_set", irq_fault, 1);
    pulse_clr();
    @(negedge clk);
    chk("t3_irq_cleared", irq_fault, 0);
    chk("t3_cnt_kept", fault_cnt, 1);
    // clear held through a faulting operation: set wins on the fault edge
    do_op(4'h1, 4'h2, 2'd3, 9, 0, 0, 1, lat, res, tries, err);
    chk("t3b_irq_set_wins", irq_fault, 1);
    chk("t3b_fault_cnt", fault_cnt, 2);
    pulse_clr();
    // response backpressure with a pending request; next accept right after handshake
    do_op(4'h7, 4'h7, 2'd0, 0, 10, 1, 0, lat, res, tries, err);
    chk("t4_result", res, 4'hE);
    do_op(4'h2, 4'h3, 2'd3, 0, 0, 0, 0, lat, res, tries, err);
    chk("t4_next_latency", lat, 3);
    chk("t4_next_result", res, 4'h3);
    // saturation of the fault counter
    for (int i = 0; i < 256; i++) do_op(4'(i), 4'(i >> 4), 2'(i), 9, 0, 0, 0, lat, res, tries, err);
    @(negedge clk);
    chk("t5_saturated", fault_cnt, 8'hFF);
    // asynchronous reset during WAIT discards the operation
    req_valid = 1; req_a = 4'h6; req_b = 4'h6; req_sel = 2'd0;
    set_bad(0, 0);
    @(posedge clk); #2;
    req_valid = 0;
    m_idle = 1; m_resp = 0; m_a = 0; m_b = 0; m_a1 = 0; m_sel = 0; m_fc = 0; m_irq = 0;
    rst_n = 0;
    #1;
    chk("t6_async_ready", req_ready, 1);
    chk("t6_async_a0", a0, 0);
    chk("t6_async_fault_cnt", fault_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_rsp", rsp_valid, 0);
    do_op(4'hA, 4'h3, 2'd0, 0, 0, 0, 0, lat, res, tries, err);
    chk("t6_after_latency", lat, 3);
    chk("t6_after_result", res, 4'hD);
`ifdef LOCKSTEP_FAULT_INJECT_EN
    inj_mask = 4'h2; inj_once = 1;
    do_op(4'h5, 4'h1, 2'd0, 1, 0, 0, 0, lat, res, tries, err);
    inj_once = 0;
    do_op(4'h5, 4'h1, 2'd0, 2, 0, 0, 0, lat, res, tries, err);
    inj_mask = 4'h0;
`endif
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
